// File: rtl/dbg_cmd_bridge_sysclk_if.sv
// rtl/dbg_cmd_bridge_sysclk_if.sv - command delivery handshake between the sysclk bridge and its consumer
interface dbg_cmd_bridge_sysclk_if #(
    parameter int IR_W = 2,
    parameter int DR_W = 38
);
    localparam int N_CODES = 2 ** IR_W;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [IR_W-1:0]    cmd_ir;
    logic [DR_W-1:0]    jdo;
    logic [N_CODES-1:0] take_action;
    logic [N_CODES-1:0] take_no_action;

    modport master (
        output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/dbg_cmd_bridge_sysclk.sv
// rtl/dbg_cmd_bridge_sysclk.sv - syncs JTAG Update-IR/DR toggles into clk, buffers commands, decodes take_* strobes
// Optional DBG_CMD_BRIDGE_EVTCNT_EN adds a 16-bit accepted-push counter on evt_count.
module dbg_cmd_bridge_sysclk #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    uir_tog,
    input  logic                    udr_tog,
    input  logic [IR_W-1:0]         ir_in,
    input  logic [DR_W-1:0]         sr,
    input  logic                    ovr_clr,
    dbg_cmd_bridge_sysclk_if.master cmd,
    output logic                    overrun,
`ifdef DBG_CMD_BRIDGE_EVTCNT_EN
    output logic [15:0]             evt_count,
`endif
    output logic                    st_ready_test_idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = IR_W + DR_W;
    localparam int MW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d, udr_sync_q, udr_sync_d;
    logic                   uir_hist_q, uir_hist_d, udr_hist_q, udr_hist_d;
    logic [MW-1:0]          mask_cnt_q, mask_cnt_d;
    logic [IR_W-1:0]        ir_q, ir_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]          last_q, last_d;
    logic                   overrun_q, overrun_d;
    logic [EW-1:0]          mem_q [DEPTH];

    logic          armed, uir_evt, udr_evt, empty, full, pop, push, drop;
    logic [EW-1:0] head, out_word;

`ifdef DBG_CMD_BRIDGE_EVTCNT_EN
    logic [15:0] evt_cnt_q, evt_cnt_d;
`endif

    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], uir_tog};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], udr_tog};
        // History tracks the last stage even while masked, so a toggle held high out of reset is absorbed.
        uir_hist_d = uir_sync_q[SYNC_STAGES-1];
        udr_hist_d = udr_sync_q[SYNC_STAGES-1];
        armed      = (mask_cnt_q == MW'(SYNC_STAGES + 1));
        mask_cnt_d = armed ? mask_cnt_q : mask_cnt_q + 1'b1;
        uir_evt    = armed & (uir_sync_q[SYNC_STAGES-1] ^ uir_hist_q);
        udr_evt    = armed & (udr_sync_q[SYNC_STAGES-1] ^ udr_hist_q);

        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head     = mem_q[rd_ptr_q[AW-1:0]];
        pop      = !empty && cmd.cmd_ready;
        push     = udr_evt && (!full || pop);
        drop     = udr_evt && full && !pop;

        ir_d      = uir_evt ? ir_in : ir_q;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_d    = pop ? head : last_q;
        overrun_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

        out_word           = empty ? last_q : head;
        cmd.cmd_valid      = !empty;
        cmd.cmd_ir         = out_word[EW-1:DR_W];
        cmd.jdo            = out_word[DR_W-1:0];
        cmd.take_action    = '0;
        cmd.take_no_action = '0;
        if (pop) begin
            if (head[DR_W-1]) cmd.take_action[head[EW-1:DR_W]]    = 1'b1;
            else              cmd.take_no_action[head[EW-1:DR_W]] = 1'b1;
        end

        overrun            = overrun_q;
        st_ready_test_idle = empty
                           && (uir_sync_q == {SYNC_STAGES{uir_hist_q}})
                           && (udr_sync_q == {SYNC_STAGES{udr_hist_q}});
`ifdef DBG_CMD_BRIDGE_EVTCNT_EN
        evt_cnt_d = push ? evt_cnt_q + 16'd1 : evt_cnt_q;
        evt_count = evt_cnt_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_hist_q <= 1'b0;
            udr_hist_q <= 1'b0;
            mask_cnt_q <= '0;
            ir_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            uir_sync_q <= uir_sync_d;
            udr_sync_q <= udr_sync_d;
            uir_hist_q <= uir_hist_d;
            udr_hist_q <= udr_hist_d;
            mask_cnt_q <= mask_cnt_d;
            ir_q       <= ir_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
            overrun_q  <= overrun_d;
        end
    end

    // Storage needs no reset: occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ir_q, sr};
    end

`ifdef DBG_CMD_BRIDGE_EVTCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) evt_cnt_q <= '0;
        else          evt_cnt_q <= evt_cnt_d;
    end
`endif
endmodule
